soc_ctrl_boot_seq: RTL and testbench
====================================

# soc_ctrl_boot_seq

Autonomous boot sequencer that drives the SoC control register file over OBI after reset. It reads the boot mode and, for autonomous boot, programs the boot address and raises fetch-enable. It then polls the core status register until the end-of-computation flag is set. It sits as an additional OBI manager on the peripheral crossbar, next to the core and the JTAG debug manager, and reports completion and the exit code to the pad/test logic.

## Interface
- `obi_req_t`, default `logic`: OBI request struct of the peripheral crossbar.
- `obi_rsp_t`, default `logic`: OBI response struct.
- `BaseAddr`, default `32'h0300_0000`: base address of the SoC control registers.
- `BootAddrAuto`, default `32'h1000_0000`: boot address written in autonomous boot mode.
- `PollCycles`, default `1024`: idle cycles between status reads; must be >= 1.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, reset is synchronous and active-low.
- `start_i`  in  1  level; sampled only in IDLE and starts the sequence.
- `obi_req_o`  out  obi_req_t  manager request.
- `obi_rsp_i`  in  obi_rsp_t  manager response.
- `busy_o`  out  1  sequence in progress (every state except IDLE, DONE and ERROR).
- `done_o`  out  1  end of computation seen; sticky until reset.
- `err_o`  out  1  OBI error response received; sticky until reset.
- `exit_code_o`  out  31  bits [30:0] of the final core status read; valid when `done_o` is high.

## Operation
- Register offsets come from `soc_ctrl_regs_pkg`: `SOC_CTRL_BOOTMODE_OFFSET`, `SOC_CTRL_BOOTADDR_OFFSET`, `SOC_CTRL_FETCHEN_OFFSET` and `SOC_CTRL_CORESTATUS_OFFSET`. Each address is `BaseAddr` plus the offset, computed as 32-bit and wrapping modulo 2^32.
- All accesses use `be=4'hF` and `aid='0`. `wdata` is `'0` on reads.
- States and transitions:
  - IDLE -> RD_MODE when `start_i` is high.
  - RD_MODE: read BOOTMODE, then WT_MODE.
  - WT_MODE: on `rvalid`, if `rdata[0]` is 1 go to WR_ADDR, otherwise go to RD_STAT. Mode 0 is passive: a host loads and starts the core via JTAG.
  - WR_ADDR: write `BootAddrAuto` to BOOTADDR, then WT_ADDR.
  - WT_ADDR: on `rvalid`, go to WR_FEN.
  - WR_FEN: write `32'h1` to FETCHEN, then WT_FEN.
  - WT_FEN: on `rvalid`, go to WAIT_POLL.
  - WAIT_POLL: load the counter with `PollCycles-1` on entry and decrement it each cycle. Go to RD_STAT in the cycle after the counter reaches 0.
  - RD_STAT: read CORESTATUS, then WT_STAT.
  - WT_STAT: on `rvalid`, if `rdata[31]` is set, latch `rdata[30:0]` into `exit_code_o` and go to DONE; otherwise go to WAIT_POLL.
  - DONE and ERROR are terminal until reset; `start_i` is ignored in both.
- In any WT_* state, `rvalid` with `err=1` goes to ERROR. No further requests are issued and `exit_code_o` is unchanged.
- `rvalid` is ignored outside WT_* states. This covers stale responses arriving after a reset.
- Poll counter width is `$clog2(PollCycles+1)`.

## Timing
- Reset values: `obi_req_o.req=0`, all A-phase fields 0, `busy_o=0`, `done_o=0`, `err_o=0`, `exit_code_o=0`. The state is IDLE and the counter is 0.
- `req` is decoded combinationally from the state and is high only in RD_MODE, WR_ADDR, WR_FEN and RD_STAT.
  - A state is left on the clock edge where `gnt` is high.
  - `addr`, `we`, `wdata` and `be` are stable while `req && !gnt`.
- At most one transaction is outstanding, and `req` is low in all WT_* states.
- `start_i` high in cycle t puts `req` high in cycle t+1.
- With zero-wait `gnt` and `rvalid` one cycle after `gnt`, each access takes 2 cycles.
- Autonomous boot, from `start_i` to the first status read request: 6 + `PollCycles` + 1 cycles.
- Status read spacing: `rvalid` in cycle t puts the next status `req` high in cycle t+`PollCycles`+1.
- `done_o`, `exit_code_o` and `err_o` update in the cycle after the deciding `rvalid`. `busy_o` falls in that same cycle.
- Synchronous reset mid-transaction drops `req` at the next edge, regardless of `gnt`.

## Test plan
- Autonomous boot: zero-wait subordinate, BOOTMODE returns 1, CORESTATUS returns `0x8000_0000` -> accesses in order:
  - read `BaseAddr+BOOTMODE`
  - write `0x1000_0000` to BOOTADDR
  - write 1 to FETCHEN
  - one read of CORESTATUS, then `done_o=1` and `exit_code_o=0`.
- Passive boot: BOOTMODE returns 0 -> no write is issued (`we` never 1); CORESTATUS is read directly after BOOTMODE.
- Grant stall: `gnt` held low for 3 cycles on the BOOTADDR write -> `req` and the A-phase fields are constant for 4 cycles, and exactly one write completes.
- Polling: CORESTATUS returns 0, 0, then `0x8000_002A` with `PollCycles=4` -> three reads, each `req` rising 5 cycles after the previous `rvalid`; then `exit_code_o=0x2A`, `done_o=1`, and no further `req`.
- Error: `err=1` on the FETCHEN write -> `err_o=1`, `busy_o=0`, no further `req`, and `start_i` is ignored until reset.
- Reset mid-poll: assert `rst_ni=0` for one cycle in WAIT_POLL, then inject a stale `rvalid` -> all outputs return to reset values and the stale `rvalid` is ignored. A new `start_i` restarts the sequence from the BOOTMODE read.

Source files
------------

// File: rtl/soc_ctrl_boot_seq.sv
// Boot sequencer: reads the boot mode over OBI, optionally programs boot address and
// fetch-enable, then polls core status until end-of-computation and reports the exit code.

package soc_ctrl_regs_pkg;
    localparam logic [31:0] SOC_CTRL_BOOTADDR_OFFSET   = 32'h0000_0004;
    localparam logic [31:0] SOC_CTRL_FETCHEN_OFFSET    = 32'h0000_0008;
    localparam logic [31:0] SOC_CTRL_CORESTATUS_OFFSET = 32'h0000_000C;
    localparam logic [31:0] SOC_CTRL_BOOTMODE_OFFSET   = 32'h0000_0010;
endpackage

package soc_ctrl_obi_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;
endpackage

module soc_ctrl_boot_seq #(
    parameter type         obi_req_t    = soc_ctrl_obi_pkg::obi_req_t,
    parameter type         obi_rsp_t    = soc_ctrl_obi_pkg::obi_rsp_t,
    parameter logic [31:0] BaseAddr     = 32'h0300_0000,
    parameter logic [31:0] BootAddrAuto = 32'h1000_0000,
    parameter int unsigned PollCycles   = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output obi_req_t    obi_req_o,
    input  obi_rsp_t    obi_rsp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [30:0] exit_code_o
);
    import soc_ctrl_regs_pkg::*;

    localparam int unsigned     CntW     = $clog2(PollCycles + 1);
    localparam logic [CntW-1:0] CntLoad  = CntW'(PollCycles - 1);
    localparam logic [31:0]     AddrMode = BaseAddr + SOC_CTRL_BOOTMODE_OFFSET;
    localparam logic [31:0]     AddrBoot = BaseAddr + SOC_CTRL_BOOTADDR_OFFSET;
    localparam logic [31:0]     AddrFen  = BaseAddr + SOC_CTRL_FETCHEN_OFFSET;
    localparam logic [31:0]     AddrStat = BaseAddr + SOC_CTRL_CORESTATUS_OFFSET;

    typedef enum logic [3:0] {
        IDLE,
        RD_MODE,
        WT_MODE,
        WR_ADDR,
        WT_ADDR,
        WR_FEN,
        WT_FEN,
        WAIT_POLL,
        RD_STAT,
        WT_STAT,
        DONE,
        ERROR
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [30:0]     exit_q, exit_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            exit_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            exit_q  <= exit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        err_d     = err_q;
        exit_d    = exit_q;
        obi_req_o = '0;

        case (state_q)
            IDLE: begin
                if (start_i) state_d = RD_MODE;
            end
            RD_MODE: begin
                obi_req_o.req  = 1'b1;
                obi_req_o.addr = AddrMode;
                obi_req_o.be   = 4'hF;
                if (obi_rsp_i.gnt) state_d = WT_MODE;
            end
            WT_MODE: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.err) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (obi_rsp_i.rdata[0]) begin
                        state_d = WR_ADDR;
                    end else begin
                        state_d = RD_STAT;
                    end
                end
            end
            WR_ADDR: begin
                obi_req_o.req   = 1'b1;
                obi_req_o.addr  = AddrBoot;
                obi_req_o.we    = 1'b1;
                obi_req_o.be    = 4'hF;
                obi_req_o.wdata = BootAddrAuto;
                if (obi_rsp_i.gnt) state_d = WT_ADDR;
            end
            WT_ADDR: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.err) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WR_FEN;
                    end
                end
            end
            WR_FEN: begin
                obi_req_o.req   = 1'b1;
                obi_req_o.addr  = AddrFen;
                obi_req_o.we    = 1'b1;
                obi_req_o.be    = 4'hF;
                obi_req_o.wdata = 32'h1;
                if (obi_rsp_i.gnt) state_d = WT_FEN;
            end
            WT_FEN: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.err) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WAIT_POLL;
                        cnt_d   = CntLoad;
                    end
                end
            end
            WAIT_POLL: begin
                // Counter hits zero one cycle before the status read goes out.
                if (cnt_q == '0) state_d = RD_STAT;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            RD_STAT: begin
                obi_req_o.req  = 1'b1;
                obi_req_o.addr = AddrStat;
                obi_req_o.be   = 4'hF;
                if (obi_rsp_i.gnt) state_d = WT_STAT;
            end
            WT_STAT: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.err) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (obi_rsp_i.rdata[31]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        exit_d  = obi_rsp_i.rdata[30:0];
                    end else begin
                        state_d = WAIT_POLL;
                        cnt_d   = CntLoad;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy_o      = !(state_q inside {IDLE, DONE, ERROR});
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign exit_code_o = exit_q;

endmodule

// File: tb/tb_soc_ctrl_boot_seq.sv
// Directed bench for soc_ctrl_boot_seq: a scripted OBI subordinate plus hand-computed expectations.

module tb_soc_ctrl_boot_seq;
    import soc_ctrl_obi_pkg::*;

    localparam int          P       = 4;
    localparam logic [31:0] A_BADDR = 32'h0300_0004;
    localparam logic [31:0] A_FEN   = 32'h0300_0008;
    localparam logic [31:0] A_STAT  = 32'h0300_000C;
    localparam logic [31:0] A_MODE  = 32'h0300_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    obi_req_t    req;
    obi_rsp_t    rsp;
    logic        busy, done, err;
    logic [30:0] exit_code;

    always #5 clk = ~clk;

    soc_ctrl_boot_seq #(
        .PollCycles(P)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .obi_req_o  (req),
        .obi_rsp_i  (rsp),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .exit_code_o(exit_code)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Subordinate model configuration and logs
    logic [31:0] bootmode_val = 32'h1;
    logic [31:0] stat_q[$];
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_n = 0;
    logic        inject = 1'b0;

    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];
    int          log_cyc[$];

    int          wait_cnt = 0;
    int          stall_seen = 0;
    int          unstable = 0;
    int          req_cycles = 0;
    obi_req_t    snap;
    logic        rv_r = 1'b0, err_r = 1'b0;
    logic [31:0] rdata_r = '0;
    logic        gnt;

    always_comb begin
        gnt        = req.req && (wait_cnt >= ((req.addr == stall_addr) ? stall_n : 0));
        rsp.gnt    = gnt;
        rsp.rvalid = rv_r;
        rsp.rdata  = rdata_r;
        rsp.err    = err_r;
    end

    always @(posedge clk) begin
        rv_r    <= 1'b0;
        err_r   <= 1'b0;
        rdata_r <= '0;
        if (inject) begin
            rv_r    <= 1'b1;
            err_r   <= 1'b1;
            rdata_r <= 32'h8000_0077;
        end
        if (req.req) begin
            req_cycles <= req_cycles + 1;
            if (wait_cnt > 0 && req != snap) unstable <= unstable + 1;
            if (!gnt) begin
                snap       <= req;
                wait_cnt   <= wait_cnt + 1;
                stall_seen <= stall_seen + 1;
            end else begin
                wait_cnt <= 0;
                log_addr.push_back(req.addr);
                log_wdata.push_back(req.wdata);
                log_we.push_back(req.we);
                log_cyc.push_back(cyc);
                $display("txn cyc=%0d addr=%h we=%0d wdata=%h be=%h", cyc, req.addr, req.we, req.wdata, req.be);
                rv_r  <= 1'b1;
                err_r <= err_en && (req.addr == err_addr);
                if (req.addr == A_MODE) rdata_r <= bootmode_val;
                else if (req.addr == A_STAT) rdata_r <= (stat_q.size() > 0) ? stat_q.pop_front() : 32'h8000_0000;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_cfg();
        bootmode_val = 32'h1;
        stat_q.delete();
        err_en = 1'b0;
        err_addr = 32'hFFFF_FFFF;
        stall_addr = 32'hFFFF_FFFF;
        stall_n = 0;
        log_addr.delete();
        log_wdata.delete();
        log_we.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick(2);
        rst_n = 1'b1;
        clear_cfg();
    endtask

    int start_cyc;
    task automatic pulse_start();
        start = 1'b1;
        start_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!done && !err && k < 400) begin
            tick(1);
            k++;
        end
        chk("end_within_bound", 32'(k < 400), 32'h1);
    endtask

    int rc, nw, nb, ns;

    initial begin
        // Reset state
        do_reset();
        chk("rst_req", 32'(req.req), 0);
        chk("rst_addr", req.addr, 0);
        chk("rst_we_be", {27'b0, req.we, req.be}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_exit", {1'b0, exit_code}, 0);

        // Autonomous boot
        bootmode_val = 32'h1;
        stat_q.push_back(32'h8000_0000);
        pulse_start();
        chk("auto_req_t1", 32'(req.req), 1);
        chk("auto_addr_t1", req.addr, A_MODE);
        chk("auto_busy", 32'(busy), 1);
        wait_end();
        tick(1);
        chk("auto_ntxn", 32'(log_addr.size()), 4);
        if (log_addr.size() == 4) begin
            chk("auto_a0", log_addr[0], A_MODE);
            chk("auto_we0", 32'(log_we[0]), 0);
            chk("auto_a1", log_addr[1], A_BADDR);
            chk("auto_d1", log_wdata[1], 32'h1000_0000);
            chk("auto_we1", 32'(log_we[1]), 1);
            chk("auto_a2", log_addr[2], A_FEN);
            chk("auto_d2", log_wdata[2], 32'h1);
            chk("auto_a3", log_addr[3], A_STAT);
            chk("auto_lat_first", 32'(log_cyc[0] - start_cyc), 1);
            chk("auto_lat_stat", 32'(log_cyc[3] - start_cyc), 32'(6 + P + 1));
        end
        chk("auto_done", 32'(done), 1);
        chk("auto_exit", {1'b0, exit_code}, 0);
        chk("auto_busy_end", 32'(busy), 0);
        rc = req_cycles;
        tick(20);
        chk("auto_no_more_req", 32'(req_cycles), 32'(rc));

        // Passive boot
        do_reset();
        bootmode_val = 32'h0;
        stat_q.push_back(32'h8000_0005);
        pulse_start();
        wait_end();
        tick(1);
        nw = 0;
        foreach (log_we[i]) if (log_we[i]) nw++;
        chk("pas_writes", 32'(nw), 0);
        chk("pas_ntxn", 32'(log_addr.size()), 2);
        if (log_addr.size() == 2) begin
            chk("pas_a1", log_addr[1], A_STAT);
            chk("pas_gap", 32'(log_cyc[1] - log_cyc[0]), 2);
        end
        chk("pas_exit", {1'b0, exit_code}, 32'h5);

        // Grant stall on BOOTADDR write
        do_reset();
        stall_addr = A_BADDR;
        stall_n = 3;
        rc = stall_seen;
        ns = unstable;
        pulse_start();
        wait_end();
        tick(1);
        chk("stall_cycles", 32'(stall_seen - rc), 3);
        chk("stall_stable", 32'(unstable - ns), 0);
        nb = 0;
        foreach (log_addr[i]) if (log_addr[i] == A_BADDR && log_we[i]) nb++;
        chk("stall_one_write", 32'(nb), 1);
        chk("stall_done", 32'(done), 1);

        // Polling
        do_reset();
        stat_q.push_back(32'h0);
        stat_q.push_back(32'h0);
        stat_q.push_back(32'h8000_002A);
        pulse_start();
        wait_end();
        tick(1);
        chk("poll_ntxn", 32'(log_addr.size()), 6);
        if (log_addr.size() == 6) begin
            chk("poll_gap1", 32'(log_cyc[4] - log_cyc[3]), 32'(P + 2));
            chk("poll_gap2", 32'(log_cyc[5] - log_cyc[4]), 32'(P + 2));
            chk("poll_a5", log_addr[5], A_STAT);
        end
        chk("poll_exit", {1'b0, exit_code}, 32'h2A);
        chk("poll_done", 32'(done), 1);
        rc = req_cycles;
        tick(20);
        chk("poll_no_more_req", 32'(req_cycles), 32'(rc));

        // Error on FETCHEN write
        do_reset();
        err_en = 1'b1;
        err_addr = A_FEN;
        pulse_start();
        wait_end();
        tick(1);
        chk("err_flag", 32'(err), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_done", 32'(done), 0);
        chk("err_exit", {1'b0, exit_code}, 0);
        chk("err_ntxn", 32'(log_addr.size()), 3);
        pulse_start();
        tick(20);
        chk("err_ignore_start", 32'(log_addr.size()), 3);
        chk("err_req_low", 32'(req.req), 0);

        // Reset mid-poll followed by a stale response
        do_reset();
        pulse_start();
        tick(7);
        chk("mid_busy_poll", 32'(busy), 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mid_req_drop", 32'(req.req), 0);
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        tick(2);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_err", 32'(err), 0);
        chk("mid_exit", {1'b0, exit_code}, 0);
        chk("mid_ntxn", 32'(log_addr.size()), 3);
        log_addr.delete();
        log_wdata.delete();
        log_we.delete();
        log_cyc.delete();
        stat_q.push_back(32'h8000_0011);
        pulse_start();
        chk("mid_restart_req", 32'(req.req), 1);
        chk("mid_restart_addr", req.addr, A_MODE);
        wait_end();
        tick(1);
        chk("mid_restart_done", 32'(done), 1);
        chk("mid_restart_exit", {1'b0, exit_code}, 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
